// File: rtl/rv_iopmp_tl_arbiter.sv
`default_nettype none
// ============================================================================
// Module      : rv_iopmp_tl_arbiter
// Description : Round-robin arbiter that shares one IOPMP check port among
//               NUM_REQ requesters. Each accepted request is held stable on
//               the check port for CHECK_LATENCY cycles, then the result is
//               returned to the granted requester as a one-cycle strobe.
//               Denied checks are counted in a saturating 16-bit counter.
// Revision    : 1.0 - initial release
// ============================================================================

package rv_iopmp_pkg;
    typedef logic [2:0] access_t;
endpackage

module rv_iopmp_tl_arbiter #(
    parameter int unsigned NUM_REQ       = 2,
    parameter int unsigned ADDR_WIDTH    = 64,
    parameter int unsigned SID_WIDTH     = 1,
    parameter int unsigned NBYTES_WIDTH  = 4,
    parameter int unsigned CHECK_LATENCY = 1
) (
    input  logic                                       clk_i,
    input  logic                                       rst_ni,
    input  logic [NUM_REQ-1:0]                         req_valid_i,
    output logic [NUM_REQ-1:0]                         req_ready_o,
    input  logic [NUM_REQ-1:0][ADDR_WIDTH-1:0]         req_addr_i,
    input  logic [NUM_REQ-1:0][NBYTES_WIDTH-1:0]       req_num_bytes_i,
    input  logic [NUM_REQ-1:0][SID_WIDTH-1:0]          req_sid_i,
    input  rv_iopmp_pkg::access_t [NUM_REQ-1:0]        req_access_type_i,
    output logic [NUM_REQ-1:0]                         rsp_valid_o,
    output logic                                       rsp_allow_o,
    output logic                                       transaction_en_o,
    output logic [ADDR_WIDTH-1:0]                      addr_o,
    output logic [NBYTES_WIDTH-1:0]                    num_bytes_o,
    output logic [SID_WIDTH-1:0]                       sid_o,
    output rv_iopmp_pkg::access_t                      access_type_o,
    input  logic                                       allow_transaction_i,
    output logic [15:0]                                deny_count_o
);

    localparam int unsigned PTR_W = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1;
    localparam int unsigned CNT_W = $clog2(CHECK_LATENCY + 1);

    localparam logic [1:0] ST_IDLE  = 2'd0;
    localparam logic [1:0] ST_CHECK = 2'd1;
    localparam logic [1:0] ST_RESP  = 2'd2;

    logic [1:0]              state_q,   state_d;
    logic [PTR_W-1:0]        rr_ptr_q,  rr_ptr_d;
    logic [PTR_W-1:0]        idx_q,     idx_d;
    logic [CNT_W-1:0]        cnt_q,     cnt_d;
    logic [ADDR_WIDTH-1:0]   addr_q,    addr_d;
    logic [NBYTES_WIDTH-1:0] nbytes_q,  nbytes_d;
    logic [SID_WIDTH-1:0]    sid_q,     sid_d;
    rv_iopmp_pkg::access_t   acc_q,     acc_d;
    logic                    allow_q,   allow_d;
    logic [15:0]             deny_cnt_q, deny_cnt_d;

    logic                    grant_found;
    logic [PTR_W-1:0]        grant_idx;

    // Round-robin search: first valid requester at or after rr_ptr, wrapping.
    always_comb begin
        int unsigned cand;
        logic [PTR_W-1:0] cand_idx;
        grant_found = 1'b0;
        grant_idx   = '0;
        cand        = 0;
        cand_idx    = '0;
        for (int unsigned i = 0; i < NUM_REQ; i++) begin
            cand = 32'(rr_ptr_q) + i;
            if (cand >= NUM_REQ) begin
                cand = cand - NUM_REQ;
            end
            cand_idx = PTR_W'(cand);
            if (!grant_found && req_valid_i[cand_idx]) begin
                grant_found = 1'b1;
                grant_idx   = cand_idx;
            end
        end
    end

    // State and datapath registers.
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            state_q    <= ST_IDLE;
            rr_ptr_q   <= '0;
            idx_q      <= '0;
            cnt_q      <= '0;
            addr_q     <= '0;
            nbytes_q   <= '0;
            sid_q      <= '0;
            acc_q      <= '0;
            allow_q    <= 1'b0;
            deny_cnt_q <= '0;
        end else begin
            state_q    <= state_d;
            rr_ptr_q   <= rr_ptr_d;
            idx_q      <= idx_d;
            cnt_q      <= cnt_d;
            addr_q     <= addr_d;
            nbytes_q   <= nbytes_d;
            sid_q      <= sid_d;
            acc_q      <= acc_d;
            allow_q    <= allow_d;
            deny_cnt_q <= deny_cnt_d;
        end
    end

    // Next-state and hold-register update: capture on grant, count latency,
    // sample the check result, advance the pointer and count denies.
    always_comb begin
        state_d    = state_q;
        rr_ptr_d   = rr_ptr_q;
        idx_d      = idx_q;
        cnt_d      = cnt_q;
        addr_d     = addr_q;
        nbytes_d   = nbytes_q;
        sid_d      = sid_q;
        acc_d      = acc_q;
        allow_d    = allow_q;
        deny_cnt_d = deny_cnt_q;
        case (state_q)
            ST_IDLE: begin
                if (grant_found) begin
                    idx_d    = grant_idx;
                    addr_d   = req_addr_i[grant_idx];
                    nbytes_d = req_num_bytes_i[grant_idx];
                    sid_d    = req_sid_i[grant_idx];
                    acc_d    = req_access_type_i[grant_idx];
                    cnt_d    = '0;
                    state_d  = ST_CHECK;
                end
            end
            ST_CHECK: begin
                cnt_d = cnt_q + 1'b1;
                if (cnt_q == CNT_W'(CHECK_LATENCY - 1)) begin
                    allow_d = allow_transaction_i;
                    state_d = ST_RESP;
                end
            end
            ST_RESP: begin
                state_d = ST_IDLE;
                // Explicit wrap keeps non-power-of-two NUM_REQ in range.
                if (idx_q == PTR_W'(NUM_REQ - 1)) begin
                    rr_ptr_d = '0;
                end else begin
                    rr_ptr_d = idx_q + 1'b1;
                end
                if (!allow_q && (deny_cnt_q != 16'hFFFF)) begin
                    deny_cnt_d = deny_cnt_q + 16'd1;
                end
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase
    end

    // Output decode; the ready path is gated by reset so every output reads
    // zero while rst_ni is low, even with requests pending.
    always_comb begin
        req_ready_o      = '0;
        rsp_valid_o      = '0;
        rsp_allow_o      = 1'b0;
        transaction_en_o = 1'b0;
        addr_o           = '0;
        num_bytes_o      = '0;
        sid_o            = '0;
        access_type_o    = '0;
        case (state_q)
            ST_IDLE: begin
                if (grant_found && rst_ni) begin
                    req_ready_o = NUM_REQ'(1) << grant_idx;
                end
            end
            ST_CHECK: begin
                transaction_en_o = 1'b1;
                addr_o           = addr_q;
                num_bytes_o      = nbytes_q;
                sid_o            = sid_q;
                access_type_o    = acc_q;
            end
            ST_RESP: begin
                rsp_valid_o = NUM_REQ'(1) << idx_q;
                rsp_allow_o = allow_q;
            end
            default: begin
            end
        endcase
    end

    assign deny_count_o = deny_cnt_q;

endmodule

`default_nettype wire
